// File: rtl/rv32i_wb_pipe_data_adapter.sv
// MEM-stage load/store port to a Wishbone B4 pipelined master with up to
// MAX_OUTSTANDING transactions in flight, in-order retirement and optional drain-on-error.

module rv32i_wb_pipe_data_adapter_chk #(
  parameter int unsigned CNT_W           = 3,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input logic             clk_i,
  input logic             rst_ni,
  input logic             abort,
  input logic             ack,
  input logic             err,
  input logic             push,
  input logic             gnt,
  input logic [CNT_W-1:0] inflight,
  input logic [CNT_W-1:0] total
);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // Bus protocol and credit sanity checks
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!((ack || err) && !abort && (inflight == CNT_ZERO)))
        else $fatal(1, "ack/err with no transaction in flight");
      assert (!(ack && err))
        else $fatal(1, "ack and err asserted together");
      assert (!(push && (inflight == MAX_CNT)))
        else $fatal(1, "tracker push while full");
      assert (!(gnt && (total == MAX_CNT)))
        else $fatal(1, "grant with no credit left");
    end
  end

endmodule

module rv32i_wb_pipe_data_adapter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter bit          ABORT_ON_ERR    = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    gnt_o,
  output logic                    rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    store_complete_o,
  output logic                    store_err_o,
  output logic                    busy_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  input  logic                    wb_stall_i
);

  localparam int unsigned SEL_W    = DATA_WIDTH / 8;
  localparam int unsigned CNT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned FIFO_LEN = 1 << CNT_W;

  localparam logic [CNT_W-1:0]    MAX_CNT   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0]    CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [FIFO_LEN-1:0] FIFO_ZERO = {FIFO_LEN{1'b0}};
  localparam logic [FIFO_LEN-1:0] FIFO_ONE  = {{(FIFO_LEN-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_ABORT = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_s;

  logic                  cmd_valid_r;
  logic                  cmd_we_r;
  logic [SEL_W-1:0]      cmd_sel_r;
  logic [ADDR_WIDTH-1:0] cmd_adr_r;
  logic [DATA_WIDTH-1:0] cmd_dat_r;
  logic [CNT_W-1:0]      inflight_r;
  logic [FIFO_LEN-1:0]   fifo_r;

  logic                  cyc_r;
  logic                  stb_r;
  logic                  busy_r;
  logic                  rsp_valid_r;
  logic [DATA_WIDTH-1:0] rsp_rdata_r;
  logic                  rsp_err_r;
  logic                  store_complete_r;
  logic                  store_err_r;

  logic                  abort_s;
  logic [CNT_W-1:0]      total_s;
  logic                  gnt_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  pop_err_s;
  logic                  head_we_s;
  logic                  cmd_valid_s;
  logic [CNT_W-1:0]      inflight_s;
  logic [CNT_W-1:0]      wr_idx_s;
  logic [FIFO_LEN-1:0]   shifted_s;
  logic [FIFO_LEN-1:0]   push_mask_s;
  logic [FIFO_LEN-1:0]   fifo_s;

  // Accept/issue/retire decisions and next-state values of the tracker
  always_comb begin
    abort_s   = (state_r == ST_ABORT);
    total_s   = inflight_r + CNT_W'(cmd_valid_r);
    gnt_s     = rst_ni && req_i && !abort_s && (!cmd_valid_r || !wb_stall_i) && (total_s < MAX_CNT);
    // During a drain the slot goes straight to the tracker without touching the bus
    push_s    = cmd_valid_r && (abort_s || !wb_stall_i);
    pop_s     = (inflight_r != CNT_ZERO) && (abort_s || wb_ack_i || wb_err_i);
    pop_err_s = abort_s || wb_err_i;
    head_we_s = fifo_r[0];

    if (gnt_s) begin
      cmd_valid_s = 1'b1;
    end else if (push_s) begin
      cmd_valid_s = 1'b0;
    end else begin
      cmd_valid_s = cmd_valid_r;
    end

    inflight_s  = inflight_r + CNT_W'(push_s) - CNT_W'(pop_s);
    wr_idx_s    = inflight_r - CNT_W'(pop_s);
    shifted_s   = pop_s ? (fifo_r >> 1'b1) : fifo_r;
    push_mask_s = push_s ? (FIFO_ONE << wr_idx_s) : FIFO_ZERO;
    fifo_s      = (shifted_s & ~push_mask_s) | (cmd_we_r ? push_mask_s : FIFO_ZERO);

    case (state_r)
      ST_RUN: begin
        if (ABORT_ON_ERR && wb_err_i && (inflight_r != CNT_ZERO)) begin
          state_s = ST_ABORT;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_ABORT: begin
        if (total_s == CNT_ZERO) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_ABORT;
        end
      end
      default: begin
        state_s = ST_RUN;
      end
    endcase
  end

  // Command slot, outstanding counter and we-bit tracker (head at bit 0)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmd_valid_r <= 1'b0;
      cmd_we_r    <= 1'b0;
      cmd_sel_r   <= {SEL_W{1'b0}};
      cmd_adr_r   <= {ADDR_WIDTH{1'b0}};
      cmd_dat_r   <= {DATA_WIDTH{1'b0}};
      inflight_r  <= CNT_ZERO;
      fifo_r      <= FIFO_ZERO;
    end else begin
      cmd_valid_r <= cmd_valid_s;
      inflight_r  <= inflight_s;
      fifo_r      <= fifo_s;
      if (gnt_s) begin
        cmd_we_r  <= we_i;
        cmd_sel_r <= we_i ? be_i : {SEL_W{1'b1}};
        cmd_adr_r <= addr_i;
        cmd_dat_r <= wdata_i;
      end
    end
  end

  // RUN/ABORT state with registered cycle, strobe and busy flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_RUN;
      cyc_r   <= 1'b0;
      stb_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cyc_r   <= (cmd_valid_s || (inflight_s != CNT_ZERO)) && (state_s != ST_ABORT);
      stb_r   <= cmd_valid_s && (state_s != ST_ABORT);
      busy_r  <= cmd_valid_s || (inflight_s != CNT_ZERO);
    end
  end

  // One-cycle response pulses for the retiring head entry
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_r      <= 1'b0;
      rsp_rdata_r      <= {DATA_WIDTH{1'b0}};
      rsp_err_r        <= 1'b0;
      store_complete_r <= 1'b0;
      store_err_r      <= 1'b0;
    end else begin
      rsp_valid_r      <= pop_s && !head_we_s;
      rsp_rdata_r      <= (pop_s && !head_we_s && !abort_s) ? wb_dat_i : {DATA_WIDTH{1'b0}};
      rsp_err_r        <= pop_s && !head_we_s && pop_err_s;
      store_complete_r <= pop_s && head_we_s;
      store_err_r      <= pop_s && head_we_s && pop_err_s;
    end
  end

  assign gnt_o            = gnt_s;
  assign rsp_valid_o      = rsp_valid_r;
  assign rsp_rdata_o      = rsp_rdata_r;
  assign rsp_err_o        = rsp_err_r;
  assign store_complete_o = store_complete_r;
  assign store_err_o      = store_err_r;
  assign busy_o           = busy_r;
  assign wb_cyc_o         = cyc_r;
  assign wb_stb_o         = stb_r;
  assign wb_we_o          = cmd_we_r;
  assign wb_sel_o         = cmd_sel_r;
  assign wb_adr_o         = cmd_adr_r;
  assign wb_dat_o         = cmd_dat_r;

  rv32i_wb_pipe_data_adapter_chk #(
    .CNT_W           (CNT_W),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_chk (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .abort    (abort_s),
    .ack      (wb_ack_i),
    .err      (wb_err_i),
    .push     (push_s),
    .gnt      (gnt_s),
    .inflight (inflight_r),
    .total    (total_s)
  );

endmodule

// File: tb/tb_rv32i_wb_pipe_data_adapter.sv
// Directed and random stimulus for rv32i_wb_pipe_data_adapter, checked cycle by cycle
// against a queue-based transaction model (pending slot queue + in-flight queue).

module tb_rv32i_wb_pipe_data_adapter;

  localparam int MAX = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i, we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i, wdata_i;
  logic        gnt_o, rsp_valid_o, rsp_err_o, store_complete_o, store_err_o, busy_o;
  logic [31:0] rsp_rdata_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_ack_i, wb_err_i, wb_stall_i;

  always #5 clk_i = ~clk_i;

  rv32i_wb_pipe_data_adapter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(MAX), .ABORT_ON_ERR(1'b1)
  ) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .be_i(be_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rsp_valid_o(rsp_valid_o),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .store_complete_o(store_complete_o),
    .store_err_o(store_err_o), .busy_o(busy_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_stall_i(wb_stall_i)
  );

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } txn_t;

  txn_t        pend[$];   // granted, not yet on the bus
  txn_t        infl[$];   // on the bus, not yet retired
  bit          m_abort;
  bit          e_rv, e_rerr, e_sc, e_serr, e_chkd;
  logic [31:0] e_rdata;
  int          total_cnt = 0;
  int          bad_cnt   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) else begin
      bad_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; addr_i = 32'h0; wdata_i = 32'h0;
    wb_stall_i = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = 32'h0;
  endtask

  function automatic bit can_ack();
    return (infl.size() > 0) && !m_abort;
  endfunction

  task automatic ack_if(input logic [31:0] d);
    if (can_ack()) begin
      wb_ack_i = 1'b1;
      wb_dat_i = d;
    end
  endtask

  task automatic clear_model();
    pend.delete(); infl.delete();
    m_abort = 1'b0;
    e_rv = 1'b0; e_rerr = 1'b0; e_sc = 1'b0; e_serr = 1'b0; e_chkd = 1'b0; e_rdata = 32'h0;
  endtask

  task automatic reset_checks();
    check("rst_gnt", gnt_o, 1'b0);           check("rst_cyc", wb_cyc_o, 1'b0);
    check("rst_stb", wb_stb_o, 1'b0);        check("rst_we", wb_we_o, 1'b0);
    check("rst_sel", wb_sel_o, 4'h0);        check("rst_adr", wb_adr_o, 32'h0);
    check("rst_dat", wb_dat_o, 32'h0);       check("rst_rsp_valid", rsp_valid_o, 1'b0);
    check("rst_rdata", rsp_rdata_o, 32'h0);  check("rst_rsp_err", rsp_err_o, 1'b0);
    check("rst_store_cpl", store_complete_o, 1'b0);
    check("rst_store_err", store_err_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
  endtask

  // Inputs are already driven; compare this cycle's outputs, then advance the model over the edge.
  task automatic step();
    int   n_pend, n_infl, tot;
    bit   egnt;
    txn_t t;
    n_pend = pend.size();
    n_infl = infl.size();
    tot    = n_pend + n_infl;
    #2;
    egnt = req_i && !m_abort && (n_pend == 0 || !wb_stall_i) && (tot < MAX);
    check("gnt", gnt_o, egnt);
    check("cyc", wb_cyc_o, (tot > 0) && !m_abort);
    check("stb", wb_stb_o, (n_pend > 0) && !m_abort);
    check("busy", busy_o, tot > 0);
    check("rsp_valid", rsp_valid_o, e_rv);
    check("store_complete", store_complete_o, e_sc);
    if (e_rv) check("rsp_err", rsp_err_o, e_rerr);
    if (e_rv && e_chkd) check("rsp_rdata", rsp_rdata_o, e_rdata);
    if (e_sc) check("store_err", store_err_o, e_serr);
    if (n_pend > 0 && !m_abort) begin
      check("bus_we", wb_we_o, pend[0].we);
      check("bus_sel", wb_sel_o, pend[0].sel);
      check("bus_adr", wb_adr_o, pend[0].adr);
      check("bus_dat", wb_dat_o, pend[0].dat);
    end
    e_rv = 1'b0; e_rerr = 1'b0; e_sc = 1'b0; e_serr = 1'b0; e_chkd = 1'b0;
    if (n_infl > 0 && (m_abort || wb_ack_i || wb_err_i)) begin
      t = infl.pop_front();
      if (t.we) begin
        e_sc = 1'b1; e_serr = m_abort || wb_err_i;
      end else begin
        e_rv = 1'b1; e_rerr = m_abort || wb_err_i; e_rdata = wb_dat_i; e_chkd = !m_abort;
      end
    end
    if (n_pend > 0 && (m_abort || !wb_stall_i)) infl.push_back(pend.pop_front());
    if (egnt) begin
      t.we = we_i; t.sel = we_i ? be_i : 4'hF; t.adr = addr_i; t.dat = wdata_i;
      pend.push_back(t);
    end
    if (m_abort) begin
      if (tot == 0) m_abort = 1'b0;
    end else if (wb_err_i && n_infl > 0) begin
      m_abort = 1'b1;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((pend.size() + infl.size() > 0) && n < budget) begin
      idle();
      ack_if($urandom);
      step();
      n++;
    end
    check("drain_within_budget", pend.size() + infl.size(), 0);
    idle();
    step();
  endtask

  task automatic load(input logic [31:0] a);
    idle(); req_i = 1'b1; addr_i = a; wdata_i = $urandom;
  endtask

  initial begin
    clear_model();
    idle();
    rst_ni = 1'b0;
    #12;
    reset_checks();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // back-to-back loads with a slave that acks as soon as something is in flight
    for (int i = 0; i < 4; i++) begin
      load(32'h100 + 32'(4 * i));
      ack_if(32'hA000_0000 + 32'(i));
      step();
    end
    drain(20);

    // credit limit: six requests with no ack, then one ack
    for (int i = 0; i < 6; i++) begin
      load(32'h200 + 32'(4 * i));
      step();
    end
    idle(); step();
    load(32'h220); wb_ack_i = 1'b1; wb_dat_i = 32'hC0DE_0001; step();
    load(32'h224); step();
    drain(20);

    // store held under three stall cycles
    idle(); req_i = 1'b1; we_i = 1'b1; be_i = 4'b0011; addr_i = 32'h300; wdata_i = 32'hDEAD_BEEF;
    step();
    for (int i = 0; i < 3; i++) begin
      idle(); wb_stall_i = 1'b1; step();
    end
    idle(); step();
    idle(); ack_if(32'h0); step();
    drain(10);

    // mixed load/store/load with consecutive acks
    load(32'h400); step();
    idle(); req_i = 1'b1; we_i = 1'b1; be_i = 4'hF; addr_i = 32'h404; wdata_i = 32'h1234_5678; step();
    load(32'h408); step();
    for (int i = 0; i < 3; i++) begin
      idle(); ack_if(32'h5500_0000 + 32'(i)); step();
    end
    drain(10);

    // abort: three loads in flight, the first errors
    for (int i = 0; i < 3; i++) begin
      load(32'h500 + 32'(4 * i)); step();
    end
    idle(); step();
    idle(); wb_err_i = 1'b1; step();
    drain(20);
    for (int i = 0; i < 3; i++) begin
      load(32'h520 + 32'(4 * i)); step();
    end
    drain(20);

    // reset with two loads in flight
    load(32'h600); step();
    load(32'h604); step();
    idle(); step();
    req_i = 1'b1;
    rst_ni = 1'b0;
    #1;
    reset_checks();
    clear_model();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    idle();
    for (int i = 0; i < 5; i++) step();

    // random traffic
    for (int c = 0; c < 600; c++) begin
      idle();
      req_i      = ($urandom_range(0, 99) < 60);
      we_i       = $urandom_range(0, 1) == 1;
      be_i       = 4'($urandom_range(0, 15));
      addr_i     = $urandom & 32'hFFFF_FFFC;
      wdata_i    = $urandom;
      wb_stall_i = ($urandom_range(0, 99) < 25);
      wb_dat_i   = $urandom;
      if (can_ack() && $urandom_range(0, 99) < 55) begin
        if ($urandom_range(0, 99) < 4) wb_err_i = 1'b1;
        else wb_ack_i = 1'b1;
      end
      step();
    end
    drain(60);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
